// File: rtl/core_mem_pkg.sv
// Shared encodings for the core/audio memory arbiter.
// State and owner enums plus the default access length.
package core_mem_pkg;

    localparam int unsigned ACC_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_AUD  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_req_latch.sv
// Request capture register: holds we/addr/wdata of one requester.
// pend is set on capture and cleared when the access completes.
module mem_req_latch #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              done,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              held_we,
    output logic [ADDR_W-1:0] held_addr,
    output logic [DATA_W-1:0] held_wdata,
    output logic              pend
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= 1'b0;
            held_we    <= 1'b0;
            held_addr  <= '0;
            held_wdata <= '0;
        end else if (capture) begin
            pend       <= 1'b1;
            held_we    <= we;
            held_addr  <= addr;
            held_wdata <= wdata;
        end else if (done) begin
            pend       <= 1'b0;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Arbitrates CPU core and audio engine requests onto one external memory,
// running fixed-length accesses and stalling the core until its access ends.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ACC_CYCLES   = ACC_CYCLES_DEFAULT,
    parameter bit          AUD_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_hold,
    input  logic              aud_req,
    input  logic              aud_we,
    input  logic [ADDR_W-1:0] aud_addr,
    input  logic [DATA_W-1:0] aud_wdata,
    output logic [DATA_W-1:0] aud_rdata,
    output logic              aud_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      CNT_W    = $clog2(ACC_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    owner_t            win;
    owner_t            loser;
    logic              loser_valid;
    logic [CNT_W-1:0]  cnt;

    logic              core_cap;
    logic              aud_cap;
    logic              core_cand;
    logic              aud_cand;
    logic              contested;
    logic              grant;
    logic              done;
    logic              core_done;
    logic              aud_done;

    logic              core_pend;
    logic              core_held_we;
    logic [ADDR_W-1:0] core_held_addr;
    logic [DATA_W-1:0] core_held_wdata;
    logic              aud_pend;
    logic              aud_held_we;
    logic [ADDR_W-1:0] aud_held_addr;
    logic [DATA_W-1:0] aud_held_wdata;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Capture qualifiers; a request captured this edge is already a candidate.
    assign core_cap  = core_req && !core_pend;
    assign aud_cap   = aud_req && !aud_pend && !aud_ack;
    assign core_cand = core_pend || core_cap;
    assign aud_cand  = aud_pend || aud_cap;
    assign contested = core_cand && aud_cand;
    assign core_done = done && (owner == OWN_CORE);
    assign aud_done  = done && (owner == OWN_AUD);
    assign core_hold = core_pend;

    mem_req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (core_cap),
        .done       (core_done),
        .we         (core_we),
        .addr       (core_addr),
        .wdata      (core_wdata),
        .held_we    (core_held_we),
        .held_addr  (core_held_addr),
        .held_wdata (core_held_wdata),
        .pend       (core_pend)
    );

    mem_req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_aud_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (aud_cap),
        .done       (aud_done),
        .we         (aud_we),
        .addr       (aud_addr),
        .wdata      (aud_wdata),
        .held_we    (aud_held_we),
        .held_addr  (aud_held_addr),
        .held_wdata (aud_held_wdata),
        .pend       (aud_pend)
    );

    // Winner selection: the previous loser breaks ties, otherwise AUD_PRIORITY.
    always_comb begin
        win = OWN_CORE;
        if (contested) begin
            if (loser_valid) begin
                win = loser;
            end else begin
                win = AUD_PRIORITY ? OWN_AUD : OWN_CORE;
            end
        end else if (aud_cand) begin
            win = OWN_AUD;
        end
    end

    // Request fields of the winner, bypassing its latch when captured this edge.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (win == OWN_AUD) begin
            sel_we    = aud_pend ? aud_held_we    : aud_we;
            sel_addr  = aud_pend ? aud_held_addr  : aud_addr;
            sel_wdata = aud_pend ? aud_held_wdata : aud_wdata;
        end else begin
            sel_we    = core_pend ? core_held_we    : core_we;
            sel_addr  = core_pend ? core_held_addr  : core_addr;
            sel_wdata = core_pend ? core_held_wdata : core_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RECOVER may grant directly: its single cycle already keeps mem_ce low.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, RECOVER: begin
                if (core_cand || aud_cand) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS: begin
                if (cnt == CNT_LAST) begin
                    done       = 1'b1;
                    state_next = RECOVER;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= OWN_CORE;
            loser       <= OWN_CORE;
            loser_valid <= 1'b0;
            cnt         <= '0;
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            core_rdata  <= '0;
            aud_rdata   <= '0;
            aud_ack     <= 1'b0;
        end else begin
            aud_ack <= 1'b0;
            if (grant) begin
                owner     <= win;
                cnt       <= '0;
                mem_ce    <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                if (contested) begin
                    loser_valid <= 1'b1;
                    loser       <= (win == OWN_AUD) ? OWN_CORE : OWN_AUD;
                end else begin
                    loser_valid <= 1'b0;
                end
            end else if (state == ACCESS) begin
                cnt <= cnt + CNT_W'(1);
                if (done) begin
                    mem_ce <= 1'b0;
                    mem_we <= 1'b0;
                    if (owner == OWN_CORE) begin
                        if (!mem_we) begin
                            core_rdata <= mem_rdata;
                        end
                    end else begin
                        if (!mem_we) begin
                            aud_rdata <= mem_rdata;
                        end
                        aud_ack <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: two instances (ACC_CYCLES 2 and 1)
// on behavioural memories, with expected read data kept in scoreboards.
module tb_core_mem_arbiter;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ACC_CYCLES = 2, audio priority
    logic          core_req_a = 1'b0, core_we_a = 1'b0;
    logic [AW-1:0] core_addr_a = '0;
    logic [DW-1:0] core_wdata_a = '0;
    logic [DW-1:0] core_rdata_a;
    logic          core_hold_a;
    logic          aud_req_a = 1'b0, aud_we_a = 1'b0;
    logic [AW-1:0] aud_addr_a = '0;
    logic [DW-1:0] aud_wdata_a = '0;
    logic [DW-1:0] aud_rdata_a;
    logic          aud_ack_a;
    logic          mem_ce_a, mem_we_a;
    logic [AW-1:0] mem_addr_a;
    logic [DW-1:0] mem_wdata_a, mem_rdata_a;

    // Instance B: ACC_CYCLES = 1, core traffic only
    logic          core_req_b = 1'b0, core_we_b = 1'b0;
    logic [AW-1:0] core_addr_b = '0;
    logic [DW-1:0] core_wdata_b = '0;
    logic [DW-1:0] core_rdata_b;
    logic          core_hold_b;
    logic          aud_req_b = 1'b0, aud_we_b = 1'b0;
    logic [AW-1:0] aud_addr_b = '0;
    logic [DW-1:0] aud_wdata_b = '0;
    logic [DW-1:0] aud_rdata_b;
    logic          aud_ack_b;
    logic          mem_ce_b, mem_we_b;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_wdata_b, mem_rdata_b;

    core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(2), .AUD_PRIORITY(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req_a), .core_we(core_we_a), .core_addr(core_addr_a),
        .core_wdata(core_wdata_a), .core_rdata(core_rdata_a), .core_hold(core_hold_a),
        .aud_req(aud_req_a), .aud_we(aud_we_a), .aud_addr(aud_addr_a),
        .aud_wdata(aud_wdata_a), .aud_rdata(aud_rdata_a), .aud_ack(aud_ack_a),
        .mem_ce(mem_ce_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(1), .AUD_PRIORITY(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req_b), .core_we(core_we_b), .core_addr(core_addr_b),
        .core_wdata(core_wdata_b), .core_rdata(core_rdata_b), .core_hold(core_hold_b),
        .aud_req(aud_req_b), .aud_we(aud_we_b), .aud_addr(aud_addr_b),
        .aud_wdata(aud_wdata_b), .aud_rdata(aud_rdata_b), .aud_ack(aud_ack_b),
        .mem_ce(mem_ce_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    function automatic logic [7:0] fold(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    // Behavioural memories with a preload port driven by the stimulus
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] shadow [256];

    assign mem_rdata_a = mem_a[fold(mem_addr_a)];
    assign mem_rdata_b = mem_b[fold(mem_addr_b)];

    always @(posedge clk) begin
        if (pre_we) begin
            mem_a[fold(pre_addr)] <= pre_data;
            mem_b[fold(pre_addr)] <= pre_data;
        end else begin
            if (mem_ce_a && mem_we_a) mem_a[fold(mem_addr_a)] <= mem_wdata_a;
            if (mem_ce_b && mem_we_b) mem_b[fold(mem_addr_b)] <= mem_wdata_b;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_core_q [$];
    logic [DW-1:0] exp_aud_q [$];
    logic          exp_own_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_core(input string tag, input logic [DW-1:0] obs);
        logic [DW-1:0] e;
        if (exp_core_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_core_q.pop_front();
            check(tag, 32'(obs), 32'(e));
        end
    endtask

    task automatic pop_aud(input string tag, input logic [DW-1:0] obs);
        logic [DW-1:0] e;
        if (exp_aud_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_aud_q.pop_front();
            check(tag, 32'(obs), 32'(e));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        shadow[fold(a)] = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic wait_hold_low_a(input string tag);
        for (int i = 0; i < 40 && core_hold_a; i++) tick();
        check({tag, "_timeout"}, 32'(core_hold_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       prev_ce;
        logic       prev_hold;
        logic       own;
        int         grants;

        // Reset and preload
        tick();
        preload(24'h008000, 16'hA5C3);
        preload(24'h000200, 16'h5A5A);
        preload(24'h000300, 16'h0F0F);
        preload(24'h000400, 16'hBEEF);
        for (int i = 0; i < 4; i++) preload(24'h000040 + AW'(i), 16'hC000 + DW'(i * 16'h0111));
        check("rst_mem_ce", 32'(mem_ce_a), 32'd0);
        check("rst_core_hold", 32'(core_hold_a), 32'd0);
        check("rst_core_rdata", 32'(core_rdata_a), 32'd0);
        check("rst_aud_ack", 32'(aud_ack_a), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // 1: uncontended core read
        core_req_a = 1'b1; core_we_a = 1'b0; core_addr_a = 24'h008000;
        exp_core_q.push_back(shadow[fold(24'h008000)]);
        tick();
        core_req_a = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            check($sformatf("t1_ce_c%0d", c), 32'(mem_ce_a), 32'd1);
            check($sformatf("t1_addr_c%0d", c), 32'(mem_addr_a), 32'h008000);
            check($sformatf("t1_we_c%0d", c), 32'(mem_we_a), 32'd0);
            check($sformatf("t1_hold_c%0d", c), 32'(core_hold_a), 32'd1);
            tick();
        end
        check("t1_hold_c3", 32'(core_hold_a), 32'd0);
        check("t1_ce_c3", 32'(mem_ce_a), 32'd0);
        pop_core("t1_rdata", core_rdata_a);

        // 2: core write, rdata unchanged, then readback
        core_req_a = 1'b1; core_we_a = 1'b1; core_addr_a = 24'h000010; core_wdata_a = 16'h1234;
        shadow[fold(24'h000010)] = 16'h1234;
        tick();
        core_req_a = 1'b0; core_we_a = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            check($sformatf("t2_ce_c%0d", c), 32'(mem_ce_a), 32'd1);
            check($sformatf("t2_we_c%0d", c), 32'(mem_we_a), 32'd1);
            check($sformatf("t2_wdata_c%0d", c), 32'(mem_wdata_a), 32'h1234);
            tick();
        end
        check("t2_hold_c3", 32'(core_hold_a), 32'd0);
        check("t2_rdata_kept", 32'(core_rdata_a), 32'hA5C3);
        core_req_a = 1'b1; core_addr_a = 24'h000010;
        exp_core_q.push_back(shadow[fold(24'h000010)]);
        tick();
        core_req_a = 1'b0;
        wait_hold_low_a("t2_rb");
        pop_core("t2_readback", core_rdata_a);

        // 3: simultaneous core and audio requests, audio first
        tick();
        tick();
        core_req_a = 1'b1; core_addr_a = 24'h000300;
        aud_req_a = 1'b1; aud_we_a = 1'b0; aud_addr_a = 24'h000200;
        exp_core_q.push_back(shadow[fold(24'h000300)]);
        exp_aud_q.push_back(shadow[fold(24'h000200)]);
        tick();
        core_req_a = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            check($sformatf("t3_ce_c%0d", c), 32'(mem_ce_a), 32'd1);
            check($sformatf("t3_aaddr_c%0d", c), 32'(mem_addr_a), 32'h000200);
            check($sformatf("t3_hold_c%0d", c), 32'(core_hold_a), 32'd1);
            tick();
        end
        check("t3_ack_c3", 32'(aud_ack_a), 32'd1);
        check("t3_ce_c3", 32'(mem_ce_a), 32'd0);
        check("t3_hold_c3", 32'(core_hold_a), 32'd1);
        pop_aud("t3_aud_rdata", aud_rdata_a);
        aud_req_a = 1'b0;
        tick();
        for (int c = 4; c <= 5; c++) begin
            check($sformatf("t3_ce_c%0d", c), 32'(mem_ce_a), 32'd1);
            check($sformatf("t3_caddr_c%0d", c), 32'(mem_addr_a), 32'h000300);
            check($sformatf("t3_hold_c%0d", c), 32'(core_hold_a), 32'd1);
            check($sformatf("t3_ack_c%0d", c), 32'(aud_ack_a), 32'd0);
            tick();
        end
        check("t3_hold_c6", 32'(core_hold_a), 32'd0);
        pop_core("t3_core_rdata", core_rdata_a);

        // 4: continuous audio plus repeated core requests alternate grants
        tick();
        tick();
        for (int i = 0; i < 6; i++) exp_own_q.push_back(i[0] == 1'b0);
        core_req_a = 1'b1; core_addr_a = 24'h000300;
        aud_req_a = 1'b1; aud_addr_a = 24'h000200;
        grants = 0;
        for (int cyc = 0; cyc < 80 && grants < 6; cyc++) begin
            prev_ce   = mem_ce_a;
            prev_hold = core_hold_a;
            tick();
            if (mem_ce_a && !prev_ce) begin
                own = (mem_addr_a == 24'h000200);
                if (exp_own_q.size() != 0) begin
                    check($sformatf("t4_grant%0d_owner", grants), 32'(own), 32'(exp_own_q.pop_front()));
                end
                grants++;
            end
            if (aud_ack_a) check("t4_aud_rdata", 32'(aud_rdata_a), 32'(shadow[fold(24'h000200)]));
            if (prev_hold && !core_hold_a) check("t4_core_rdata", 32'(core_rdata_a), 32'(shadow[fold(24'h000300)]));
        end
        check("t4_grants_seen", 32'(grants), 32'd6);
        core_req_a = 1'b0;
        aud_req_a = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("t4_drained_hold", 32'(core_hold_a), 32'd0);
        check("t4_drained_ce", 32'(mem_ce_a), 32'd0);

        // 5: reset in the middle of a core read
        core_req_a = 1'b1; core_addr_a = 24'h000400;
        tick();
        core_req_a = 1'b0;
        check("t5_ce_before", 32'(mem_ce_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ce", 32'(mem_ce_a), 32'd0);
        check("t5_rst_hold", 32'(core_hold_a), 32'd0);
        check("t5_rst_rdata", 32'(core_rdata_a), 32'd0);
        check("t5_rst_addr", 32'(mem_addr_a), 32'd0);
        check("t5_rst_we", 32'(mem_we_a), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("t5_no_update", 32'(core_rdata_a), 32'd0);
        check("t5_idle_ce", 32'(mem_ce_a), 32'd0);
        core_req_a = 1'b1; core_addr_a = 24'h000400;
        exp_core_q.push_back(shadow[fold(24'h000400)]);
        tick();
        core_req_a = 1'b0;
        wait_hold_low_a("t5_after");
        pop_core("t5_after_rdata", core_rdata_a);

        // 6: ACC_CYCLES=1 back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            core_req_b = 1'b1; core_addr_b = 24'h000040 + AW'(i);
            exp_core_q.push_back(shadow[fold(24'h000040 + AW'(i))]);
            tick();
            core_req_b = 1'b0;
            check($sformatf("t6_ce_f%0d", i), 32'(mem_ce_b), 32'd1);
            check($sformatf("t6_hold_f%0d", i), 32'(core_hold_b), 32'd1);
            check($sformatf("t6_addr_f%0d", i), 32'(mem_addr_b), 32'(24'h000040 + AW'(i)));
            tick();
            check($sformatf("t6_gap_ce_f%0d", i), 32'(mem_ce_b), 32'd0);
            check($sformatf("t6_gap_hold_f%0d", i), 32'(core_hold_b), 32'd0);
            pop_core($sformatf("t6_rdata_f%0d", i), core_rdata_b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
